// File: rtl/clock_pkg.sv
// Shared widths, defaults and state encoding for the LED clock.
// Also holds the saturating-wrap increment helpers.
package clock_pkg;

  localparam int HOUR_W    = 5;
  localparam int MIN_W     = 6;
  localparam int H_MAX_DEF = 23;
  localparam int M_MAX_DEF = 59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  // >= rather than == so a field can never step past its max
  function automatic logic [HOUR_W-1:0] inc_hour(
    input logic [HOUR_W-1:0] v,
    input logic [HOUR_W-1:0] max
  );
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] inc_min(
    input logic [MIN_W-1:0] v,
    input logic [MIN_W-1:0] max
  );
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with configurable history reset value.
// A high reset value suppresses a false edge from an already-high input.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/led_clock_ctrl.sv
// HH:MM:SS time-keeping and button-driven set-mode controller.
// All outputs are registered; field updates happen on detected rises.
module led_clock_ctrl
  import clock_pkg::*;
#(
  parameter int H_MAX = H_MAX_DEF,
  parameter int M_MAX = M_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sq_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [MIN_W-1:0]  seconds,
  output logic              blank_hour,
  output logic              blank_min,
  output logic              sec_pulse,
  output logic              day_pulse,
  output logic              set_mode
);

  localparam logic [HOUR_W-1:0] HMAX = HOUR_W'(H_MAX);
  localparam logic [MIN_W-1:0]  MMAX = MIN_W'(M_MAX);

  logic sq_rise, mode_rise, inc_rise;

  rise_detect #(.RESET_VAL(1'b1)) u_sq (
    .clk(clk), .reset(reset),
    .d(sq_1hz), .rise(sq_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_mode (
    .clk(clk), .reset(reset),
    .d(btn_mode), .rise(mode_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_inc (
    .clk(clk), .reset(reset),
    .d(btn_inc), .rise(inc_rise)
  );

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [MIN_W-1:0]  sec_q, sec_d;
  logic              sp_q, sp_d;
  logic              dp_q, dp_d;
  logic              bh_q, bh_d;
  logic              bm_q, bm_d;

  logic sec_wrap, min_wrap, hour_wrap;

  assign sec_wrap  = sec_q >= MMAX;
  assign min_wrap  = min_q >= MMAX;
  assign hour_wrap = hours_q >= HMAX;

  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    sp_d    = 1'b0;
    dp_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mode_rise) begin
          state_d = SET_HOUR;
          sec_d   = '0;
        end else if (sq_rise) begin
          sp_d  = 1'b1;
          sec_d = inc_min(sec_q, MMAX);
          if (sec_wrap) begin
            min_d = inc_min(min_q, MMAX);
            if (min_wrap) begin
              hours_d = inc_hour(hours_q, HMAX);
              dp_d    = hour_wrap;
            end
          end
        end
      end
      SET_HOUR: begin
        if (mode_rise)     state_d = SET_MIN;
        else if (inc_rise) hours_d = inc_hour(hours_q, HMAX);
      end
      SET_MIN: begin
        if (mode_rise)     state_d = RUN;
        else if (inc_rise) min_d = inc_min(min_q, MMAX);
      end
      default: state_d = RUN;
    endcase
    // keyed on next state so blanking lines up with set_mode
    bh_d = (state_d == SET_HOUR) & ~sq_1hz;
    bm_d = (state_d == SET_MIN) & ~sq_1hz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      hours_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      sp_q    <= 1'b0;
      dp_q    <= 1'b0;
      bh_q    <= 1'b0;
      bm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      bh_q    <= bh_d;
      bm_q    <= bm_d;
    end
  end

  assign hours      = hours_q;
  assign minutes    = min_q;
  assign seconds    = sec_q;
  assign blank_hour = bh_q;
  assign blank_min  = bm_q;
  assign sec_pulse  = sp_q;
  assign day_pulse  = dp_q;
  assign set_mode   = (state_q != RUN);

endmodule

// File: tb/tb_led_clock_ctrl.sv
// Directed plus random bench for led_clock_ctrl against a
// time-of-day reference model.
module tb_led_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst, sq, bm, bi;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       blank_hour, blank_min;
  logic       sec_pulse, day_pulse, set_mode;

  always #5 clk = ~clk;

  led_clock_ctrl dut (
    .clk(clk), .reset(rst),
    .sq_1hz(sq), .btn_mode(bm), .btn_inc(bi),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .blank_hour(blank_hour), .blank_min(blank_min),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse),
    .set_mode(set_mode)
  );

  int compared = 0;
  int mism     = 0;
  int n_sp     = 0;
  int n_dp     = 0;

  // model: time of day in seconds, mode 0=run 1=set hour 2=set min
  int m_tod, m_st;
  bit m_sp, m_dp, m_bh, m_bm;
  bit p_sq, p_m, p_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rs, rm, ri;
    int h, m;
    if (rst) begin
      m_tod = 0; m_st = 0;
      m_sp = 0; m_dp = 0; m_bh = 0; m_bm = 0;
      p_sq = 1; p_m = 1; p_i = 1;
    end else begin
      rs = sq & ~p_sq;
      rm = bm & ~p_m;
      ri = bi & ~p_i;
      m_sp = 0; m_dp = 0;
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      if (m_st == 0) begin
        if (rm) begin
          m_st = 1;
          m_tod = m_tod - (m_tod % 60);
        end else if (rs) begin
          m_tod = (m_tod + 1) % 86400;
          m_sp = 1;
          m_dp = (m_tod == 0);
        end
      end else if (m_st == 1) begin
        if (rm) m_st = 2;
        else if (ri)
          m_tod = ((h + 1) % 24) * 3600 + (m_tod % 3600);
      end else begin
        if (rm) m_st = 0;
        else if (ri)
          m_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
      end
      m_bh = (m_st == 1) && !sq;
      m_bm = (m_st == 2) && !sq;
      p_sq = sq; p_m = bm; p_i = bi;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (sec_pulse === 1'b1) n_sp++;
    if (day_pulse === 1'b1) n_dp++;
    chk("hours",      hours,      m_tod / 3600);
    chk("minutes",    minutes,    (m_tod / 60) % 60);
    chk("seconds",    seconds,    m_tod % 60);
    chk("sec_pulse",  sec_pulse,  m_sp);
    chk("day_pulse",  day_pulse,  m_dp);
    chk("set_mode",   set_mode,   m_st != 0);
    chk("blank_hour", blank_hour, m_bh);
    chk("blank_min",  blank_min,  m_bm);
  endtask

  task automatic sq_period();
    sq = 1'b0;
    repeat (3) tick();
    sq = 1'b1;
    repeat (3) tick();
  endtask

  task automatic press_mode();
    bm = 1'b1;
    repeat (2) tick();
    bm = 1'b0;
    repeat (2) tick();
  endtask

  // toggles sq while pressing so set mode must ignore second rises
  task automatic press_inc(input bit tog);
    bi = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (tog) sq = ~sq;
      tick();
    end
    bi = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (tog) sq = ~sq;
      tick();
    end
  endtask

  task automatic chk_time(input string tag,
                          input int h, input int m, input int s);
    chk({tag, ".h"}, hours, h);
    chk({tag, ".m"}, minutes, m);
    chk({tag, ".s"}, seconds, s);
  endtask

  initial begin
    rst = 1'b1; sq = 1'b1; bm = 1'b0; bi = 1'b0;

    // reset with sq high, then three seconds
    repeat (2) tick();
    chk_time("reset", 0, 0, 0);
    chk("reset.set_mode", set_mode, 0);
    rst = 1'b0;
    tick();
    chk_time("no_false_sec", 0, 0, 0);
    n_sp = 0;
    repeat (3) sq_period();
    chk_time("three_sec", 0, 0, 3);
    chk("three_sec.pulses", n_sp, 3);

    // set 23:59:00 then run to 23:59:58
    press_mode();
    chk("enter_set.sec_clr", seconds, 0);
    repeat (23) press_inc(1'b1);
    press_mode();
    repeat (59) press_inc(1'b1);
    sq = 1'b1;
    press_mode();
    chk_time("set_2359", 23, 59, 0);
    repeat (58) sq_period();
    chk_time("at_235958", 23, 59, 58);
    sq_period();
    chk_time("at_235959", 23, 59, 59);
    n_dp = 0;
    sq = 1'b0;
    repeat (3) tick();
    sq = 1'b1;
    tick();
    chk("rollover.day_pulse", day_pulse, 1);
    chk_time("rollover", 0, 0, 0);
    tick();
    chk("rollover.day_pulse_end", day_pulse, 0);
    chk("rollover.day_count", n_dp, 1);
    tick();

    // from 00:00:17 set to 05:02
    repeat (17) sq_period();
    chk_time("at_000017", 0, 0, 17);
    press_mode();
    repeat (5) press_inc(1'b1);
    press_mode();
    repeat (62) press_inc(1'b1);
    sq = 1'b1;
    press_mode();
    chk_time("set_0502", 5, 2, 0);
    chk("set_0502.run", set_mode, 0);

    // simultaneous mode and inc in SET_HOUR
    press_mode();
    bm = 1'b1; bi = 1'b1;
    tick();
    chk("simul.hours", hours, 5);
    bm = 1'b0; bi = 1'b0;
    repeat (2) tick();
    chk("simul.set_mode", set_mode, 1);
    chk("simul.blank_hour", blank_hour, 0);
    press_mode();
    press_mode();
    for (int k = 0; k < 6; k++) begin
      sq = k[0];
      tick();
      chk("blink.blank_hour", blank_hour, !sq);
      chk("blink.blank_min", blank_min, 0);
    end
    press_mode();
    press_mode();

    // inc held across reset release
    rst = 1'b1; bi = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk_time("held_inc", 0, 0, 0);
    bi = 1'b0;
    tick();
    press_mode();
    press_mode();
    repeat (59) press_inc(1'b0);
    chk_time("min59", 0, 59, 0);
    press_inc(1'b0);
    chk_time("min_wrap", 0, 0, 0);

    // reset during SET_MIN at 07:30
    press_mode();
    press_mode();
    repeat (7) press_inc(1'b1);
    press_mode();
    repeat (30) press_inc(1'b1);
    chk_time("at_0730", 7, 30, 0);
    rst = 1'b1;
    tick();
    chk_time("mid_reset", 0, 0, 0);
    chk("mid_reset.set_mode", set_mode, 0);
    chk("mid_reset.sec_pulse", sec_pulse, 0);
    chk("mid_reset.day_pulse", day_pulse, 0);
    rst = 1'b0;
    tick();

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(3) == 0) sq = ~sq;
      if ($urandom_range(9) == 0) bm = ~bm;
      if ($urandom_range(3) == 0) bi = ~bi;
      rst = ($urandom_range(499) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule

// File: doc/led_clock_ctrl.md
Name: led_clock_ctrl

Overview:
Time-keeping and set-mode controller for the LED clock. Consumes the 1 Hz square wave from the seconds divider (toggles every half-second, resets high). Advances an HH:MM:SS count and sequences a button-driven set mode. Feeds the display/LED driver with time fields, blink masks and a per-second strobe.

Parameters:
H_MAX, 23, last hour value before wrap (11 for a 12-field 0..11 clock)
M_MAX, 59, last minute/second value before wrap

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
sq_1hz  in  1  1 Hz square wave from divider; rising edge = one second
btn_mode  in  1  debounced level, mode button
btn_inc  in  1  debounced level, increment button
hours  out  5  current hour, 0..H_MAX
minutes  out  6  current minute, 0..M_MAX
seconds  out  6  current second, 0..M_MAX
blank_hour  out  1  1 = display should blank hour field
blank_min  out  1  1 = display should blank minute field
sec_pulse  out  1  one-cycle strobe when seconds advances
day_pulse  out  1  one-cycle strobe on H_MAX:M_MAX:M_MAX -> 00:00:00
set_mode  out  1  1 while in SET_HOUR or SET_MIN

Behaviour:
- Reset: clk clock reset reset, synchronous, active-high (already decided).
- Reset values: all time fields 0, state RUN, all strobes 0, blank_* 0, set_mode 0.
- Reset values of edge-detector history registers: 1.
  - sq_1hz resets high at the divider, so no false second is counted after reset.
  - A button held through reset is not counted until it is released and pressed again.
- Edge detection: rise = input & ~prev; prev <= input every cycle.
  - Every state update occurs on the clock edge where rise is true.
  - Outputs are registered: visible 1 cycle after the input is first sampled high.
- FSM states: RUN, SET_HOUR, SET_MIN.
- RUN:
  - On sq rise, seconds+1. At M_MAX, seconds wraps to 0 and minutes+1.
  - At minutes M_MAX, minutes wraps to 0 and hours+1.
  - At hours H_MAX, hours wraps to 0 and day_pulse=1 for that cycle.
  - sec_pulse=1 in the same cycle the seconds field changes.
  - mode rise -> SET_HOUR; seconds cleared to 0 on the same edge.
- SET_HOUR:
  - inc rise -> hours+1, wraps H_MAX->0, no day_pulse.
  - mode rise -> SET_MIN.
- SET_MIN:
  - inc rise -> minutes+1, wraps M_MAX->0, no carry into hours.
  - mode rise -> RUN. Counting restarts from seconds=0 on the next sq rise.
- In SET_* states, sq rises are ignored: no time change, no sec_pulse.
- Blanking:
  - blank_hour = set state SET_HOUR & ~sq_1hz (registered).
  - blank_min = set state SET_MIN & ~sq_1hz (registered).
  - Result is 0.5 s on / 0.5 s off; always 0 in RUN.
- Simultaneous events (same cycle):
  - mode rise + inc rise: mode wins, inc is discarded.
  - mode rise + sq rise in RUN: transition wins, seconds cleared, no sec_pulse.
- Reset mid-operation (any state, any partial count) returns to reset values on the next edge. No pending press or second survives.
- Fields never hold values above their max, even transiently.

Decomposition:
- Shared package clock_pkg:
  - widths HOUR_W=5, MIN_W=6;
  - default H_MAX=23, M_MAX=59;
  - state encoding RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2.
- One sub-module: rise_detect.
  - Parameter RESET_VAL; ports clk, reset, d, rise.
  - Instantiated three times: sq_1hz, btn_mode, btn_inc.
- Counter/carry logic and the FSM stay in led_clock_ctrl.

Test Plan:
- Reset with sq_1hz=1, then 3 sq periods -> 00:00:03, exactly 3 sec_pulse strobes, each 1 cycle after sq is sampled high.
- Start at 23:59:58 via set mode, 2 sq rises -> 23:59:59 then 00:00:00, day_pulse=1 in that single cycle.
- mode press, 5 inc presses, mode, 62 inc presses, mode from 00:00:17:
  - expected result 05:02:00, RUN;
  - no sq-driven changes while set_mode=1.
- In SET_HOUR, mode and inc rise in the same cycle -> state SET_MIN, hours unchanged. Also check blank_hour tracks ~sq_1hz.
- Hold btn_inc high across reset release -> no increment. Release then press in SET_MIN at minutes=59 -> minutes=0, hours unchanged.
- Assert reset during SET_MIN at 07:30 -> next cycle 00:00:00, RUN, set_mode=0, all strobes 0.
